// File: rtl/arbitro_bus_3_pkg.sv
// rtl/arbitro_bus_3_pkg.sv - shared types, constants and round-robin helper for the 3-way bus arbiter
package arbitro_bus_3_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd3;

  // First requester found scanning last_idx+1, +2, +3 (mod 3); 0 when nobody requests.
  function automatic logic [1:0] next_rr(input logic [2:0] req, input logic [1:0] last_idx);
    logic [1:0] pick;
    int c;
    pick = 2'd0;
    for (int j = 3; j >= 1; j--) begin
      c = (int'(last_idx) + j) % 3;
      if (req[c]) pick = 2'(c);
    end
    return pick;
  endfunction

endpackage

// File: rtl/arbitro_bus_3_if.sv
// rtl/arbitro_bus_3_if.sv - requester/consumer bus bundle seen by the arbiter
interface arbitro_bus_3_if;
  logic [2:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  grant;
  logic [1:0]  sel;

  modport master (
    input  req, data0, data1, data2, out_ready,
    output out_valid, out_data, out_last, grant, sel
  );

  modport slave (
    output req, data0, data1, data2, out_ready,
    input  out_valid, out_data, out_last, grant, sel
  );
endinterface

// File: rtl/arbitro_bus_3_mux.sv
// rtl/arbitro_bus_3_mux.sv - 3-input 32-bit select mux; select 3 drives zero
module Mux_2a4 (
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [1:0]  sel,
  output logic [31:0] y
);

  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = 32'd0;
    endcase
  end

endmodule

// File: rtl/arbitro_bus_3.sv
// rtl/arbitro_bus_3.sv - round-robin arbiter sharing one 32-bit result bus among three requesters
module arbitro_bus_3
  import arbitro_bus_3_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  arbitro_bus_3_if.master bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [1:0]      last_idx;
  logic [1:0]      sel_q;
  logic [2:0]      grant_q;
  logic [1:0]      nxt_idx;
  logic            req_sel;
  logic            at_max;

  // grant_q is zero in IDLE, so this masks req without indexing by sel.
  assign req_sel = |(bus.req & grant_q);
  assign at_max  = (count == CW'(MAX_BURST - 1));
  assign nxt_idx = next_rr(bus.req, last_idx);

  assign bus.out_valid = req_sel;
  assign bus.out_last  = req_sel & at_max;
  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;

  Mux_2a4 u_mux (
    .d0  (bus.data0),
    .d1  (bus.data1),
    .d2  (bus.data2),
    .sel (sel_q),
    .y   (bus.out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= 3'b000;
      sel_q    <= SEL_NONE;
      count    <= '0;
      last_idx <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= BUSY;
            grant_q <= 3'b001 << nxt_idx;
            sel_q   <= nxt_idx;
            count   <= '0;
          end
        end
        BUSY: begin
          // Withdraw and final accepted beat both release with one IDLE bubble.
          if (!req_sel || (bus.out_ready && at_max)) begin
            state    <= IDLE;
            last_idx <= sel_q;
            grant_q  <= 3'b000;
            sel_q    <= SEL_NONE;
          end else if (bus.out_ready) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_bus_3.sv
// tb/tb_arbitro_bus_3.sv - scoreboard bench for arbitro_bus_3 at MAX_BURST 4 and 1
module tb_arbitro_bus_3;

  localparam int MB [2] = '{4, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  req_d;
  logic        rdy_d;
  logic [31:0] dat [2][3];

  arbitro_bus_3_if b4 ();
  arbitro_bus_3_if b1 ();

  arbitro_bus_3 #(.MAX_BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  arbitro_bus_3 #(.MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  assign b4.req = req_d;
  assign b4.out_ready = rdy_d;
  assign b4.data0 = dat[0][0];
  assign b4.data1 = dat[0][1];
  assign b4.data2 = dat[0][2];
  assign b1.req = req_d;
  assign b1.out_ready = rdy_d;
  assign b1.data0 = dat[1][0];
  assign b1.data1 = dat[1][1];
  assign b1.data2 = dat[1][2];

  logic        ov [2];
  logic        ol [2];
  logic [31:0] od [2];
  logic [2:0]  gr [2];
  logic [1:0]  sl [2];
  assign ov[0] = b4.out_valid;
  assign ol[0] = b4.out_last;
  assign od[0] = b4.out_data;
  assign gr[0] = b4.grant;
  assign sl[0] = b4.sel;
  assign ov[1] = b1.out_valid;
  assign ol[1] = b1.out_last;
  assign od[1] = b1.out_data;
  assign gr[1] = b1.grant;
  assign sl[1] = b1.sel;

  typedef struct {
    int          g;
    logic [31:0] d;
    logic        last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  // Reference: who holds the bus, beats taken in this grant, previous owner.
  int          m_busy [2];
  int          m_g    [2];
  int          m_cnt  [2];
  int          m_last [2];
  int          sent   [2][3];
  logic [31:0] base   [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++)
        dat[k][i] = base[i] + 32'(sent[k][i]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0;
      m_g[k]    = 0;
      m_cnt[k]  = 0;
      m_last[k] = 2;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k] == 0) begin
        if (req_d != 3'b000) begin
          for (int j = 3; j >= 1; j--)
            if (req_d[(m_last[k] + j) % 3]) m_g[k] = (m_last[k] + j) % 3;
          m_busy[k] = 1;
          m_cnt[k]  = 0;
        end
      end else if (!req_d[m_g[k]]) begin
        m_busy[k] = 0;
        m_last[k] = m_g[k];
      end else if (rdy_d) begin
        sent[k][m_g[k]]++;
        m_cnt[k]++;
        if (m_cnt[k] == MB[k]) begin
          m_busy[k] = 0;
          m_last[k] = m_g[k];
        end
      end
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic rd);
    bit    ev;
    beat_t b;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("grant[%0d]", k), 32'(gr[k]), m_busy[k] != 0 ? 32'(1 << m_g[k]) : 32'd0);
      chk($sformatf("sel[%0d]", k), 32'(sl[k]), m_busy[k] != 0 ? 32'(m_g[k]) : 32'd3);
    end
    req_d = r;
    rdy_d = rd;
    set_data();
    #1;
    for (int k = 0; k < 2; k++) begin
      ev = (m_busy[k] != 0) && req_d[m_g[k]];
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(ev));
      chk($sformatf("out_last[%0d]", k), 32'(ol[k]), 32'(ev && (m_cnt[k] == MB[k] - 1)));
      if (ev) chk($sformatf("out_data[%0d]", k), od[k], dat[k][m_g[k]]);
      if (ev && rd) begin
        b.g    = m_g[k];
        b.d    = dat[k][m_g[k]];
        b.last = (m_cnt[k] == MB[k] - 1);
        if (k == 0) q0.push_back(b);
        else q1.push_back(b);
      end
    end
  endtask

  task automatic step(input logic [2:0] r, input logic rd);
    drive(r, rd);
    model_edge();
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #1;
    req_d = 3'b000;
    rdy_d = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) base[i] = $urandom;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) sent[k][i] = 0;
    set_data();
    model_reset();
    #1;
    rst = 1'b0;
    model_edge();
  endtask

  always @(negedge clk) begin : monitor
    beat_t b;
    int    have;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        have = (k == 0) ? q0.size() : q1.size();
        if (have > 0) b = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (ov[k] && rdy_d) begin
          if (have == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat[%0d] actual=grant %b required=no beat", k, gr[k]);
          end else begin
            chk($sformatf("beat_grant[%0d]", k), 32'(gr[k]), 32'(1 << b.g));
            chk($sformatf("beat_data[%0d]", k), od[k], b.d);
            chk($sformatf("beat_last[%0d]", k), 32'(ol[k]), 32'(b.last));
          end
        end else if (have > 0) begin
          checks++;
          errors++;
          $display("FAIL missing_beat[%0d] actual=no beat required=beat from %0d", k, b.g);
        end
        if (sl[k] == 2'd3) begin
          chk($sformatf("idle_data[%0d]", k), od[k], 32'd0);
          chk($sformatf("idle_valid[%0d]", k), 32'(ov[k]), 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    req_d = 3'b000;
    rdy_d = 1'b0;
    for (int i = 0; i < 3; i++) base[i] = $urandom;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) sent[k][i] = 0;
    set_data();
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_grant[%0d]", k), 32'(gr[k]), 32'd0);
      chk($sformatf("rst_sel[%0d]", k), 32'(sl[k]), 32'd3);
      chk($sformatf("rst_valid[%0d]", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_last[%0d]", k), 32'(ol[k]), 32'd0);
      chk($sformatf("rst_data[%0d]", k), od[k], 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_edge();

    // All three requesting, consumer always ready.
    repeat (40) step(3'b111, 1'b1);

    // Lone requester stalled by the consumer.
    hard_reset();
    base[1] = 32'hCAFE_0001;
    set_data();
    repeat (4) step(3'b010, 1'b0);
    repeat (6) step(3'b010, 1'b1);

    // Requester 2 withdraws mid-burst while requester 0 waits.
    hard_reset();
    n = 0;
    while (!(m_busy[0] != 0 && m_g[0] == 2 && m_cnt[0] == 2) && n < 20) begin
      step(3'b100, 1'b1);
      n++;
    end
    chk("withdraw_setup", 32'(m_busy[0] != 0 && m_g[0] == 2 && m_cnt[0] == 2), 32'd1);
    repeat (4) step(3'b001, 1'b1);

    // Two requesters alternating; single-beat instance exercises out_last every beat.
    hard_reset();
    repeat (16) step(3'b101, 1'b1);

    // Asynchronous reset landing between clock edges during a beat.
    hard_reset();
    repeat (3) step(3'b111, 1'b1);
    drive(3'b111, 1'b1);
    #5;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_grant[%0d]", k), 32'(gr[k]), 32'd0);
      chk($sformatf("async_sel[%0d]", k), 32'(sl[k]), 32'd3);
      chk($sformatf("async_valid[%0d]", k), 32'(ov[k]), 32'd0);
    end
    #1;
    rst = 1'b0;
    model_reset();
    model_edge();
    step(3'b111, 1'b1);
    for (int k = 0; k < 2; k++) chk($sformatf("post_rst_grant[%0d]", k), 32'(gr[k]), 32'b001);
    repeat (6) step(3'b111, 1'b1);

    // New request appearing while requester 1 owns the bus.
    hard_reset();
    n = 0;
    while (!(m_busy[0] != 0 && m_g[0] == 1) && n < 10) begin
      step(3'b010, 1'b1);
      n++;
    end
    chk("late_req_setup", 32'(m_busy[0] != 0 && m_g[0] == 1), 32'd1);
    repeat (12) step(3'b011, 1'b1);

    // Random traffic.
    hard_reset();
    repeat (400) step(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
